// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: NUM_CH-channel 1R1W word memory sitting between the cache
// fill/fetch engines and backing storage. It has independent read and write
// arbiters (round-robin or fixed priority), byte-strobed writes, and a
// write-first bypass when a read and a write hit the same word in one cycle.
// The read path takes 1 or 2 cycles.
module mem_arb_ctrl #(
  parameter int  DEPTH  = 32,
  parameter int  DW     = 32,
  parameter int  NUM_CH = 2,
  parameter bit  ARB_RR = 1'b1,
  parameter int  RD_LAT = 1,
  localparam int AW     = $clog2(DEPTH),
  localparam int SW     = DW / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    ch_ren,
  input  logic [NUM_CH*AW-1:0] ch_raddr,
  output logic [NUM_CH-1:0]    ch_rready,
  input  logic [NUM_CH-1:0]    ch_wen,
  input  logic [NUM_CH*AW-1:0] ch_waddr,
  input  logic [NUM_CH*DW-1:0] ch_wdata,
  input  logic [NUM_CH*SW-1:0] ch_wstrb,
  output logic [NUM_CH-1:0]    ch_wready,
  output logic [DW-1:0]        rdata,
  output logic [NUM_CH-1:0]    rvalid
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] idx;
  } grant_t;

  // Pick one requester. The search starts at ptr for round-robin, or at 0 for
  // fixed priority, and wraps modulo NUM_CH.
  function automatic grant_t pick(input logic [NUM_CH-1:0] req,
                                  input logic [PW-1:0]     ptr);
    grant_t g;
    int     start;
    int     idx;
    g     = '0;
    start = ARB_RR ? int'(ptr) : 0;
    // Walk the search order backwards. The requester closest to 'start' is
    // then assigned last, so it wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = (start + i) % NUM_CH;
      if (req[idx]) begin
        g.vld = 1'b1;
        g.idx = PW'(idx);
      end
    end
    return g;
  endfunction

  // The channel after the winner becomes the head of the next search.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    return PW'((int'(idx) + 1) % NUM_CH);
  endfunction

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  grant_t        rd_gnt;
  grant_t        wr_gnt;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic [DW-1:0] wr_mask;
  logic [DW-1:0] wr_merged;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] mem [DEPTH];

  // Arbitration: a grant is one-hot and is only ever given to a requester.
  always_comb begin
    // NOTE: every signal in a combinational block gets a default before any
    // conditional assignment. This prevents latches from being inferred.
    ch_rready = '0;
    ch_wready = '0;
    rd_gnt    = pick(ch_ren, rd_ptr);
    wr_gnt    = pick(ch_wen, wr_ptr);
    if (rd_gnt.vld) ch_rready[rd_gnt.idx] = 1'b1;
    if (wr_gnt.vld) ch_wready[wr_gnt.idx] = 1'b1;
  end

  // Steer the winning channel's fields and form the byte-merged write word.
  // If a read and a write target the same address, the read returns the merged
  // word (write-first).
  always_comb begin
    wr_mask = '0;
    rd_addr = ch_raddr[rd_gnt.idx*AW +: AW];
    wr_addr = ch_waddr[wr_gnt.idx*AW +: AW];
    wr_data = ch_wdata[wr_gnt.idx*DW +: DW];
    wr_strb = ch_wstrb[wr_gnt.idx*SW +: SW];
    for (int b = 0; b < SW; b++) begin
      wr_mask[8*b +: 8] = {8{wr_strb[b]}};
    end
    wr_merged = (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    rd_word   = mem[rd_addr];
    if (wr_gnt.vld && (wr_addr == rd_addr)) begin
      rd_word = wr_merged;
    end
  end

  // Storage write. A strobe of zero rewrites the old word, so it is a no-op.
  // NOTE: the storage array has no reset. Clearing every word would cost a
  // reset net into the whole array, and no reader depends on its contents
  // after reset.
  always_ff @(posedge clk) begin
    if (wr_gnt.vld) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  // Round-robin pointers. Each pointer advances only when its own handshake
  // occurs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments. All flops then
    // sample their inputs together at the edge, regardless of statement order.
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (rd_gnt.vld) rd_ptr <= next_ptr(rd_gnt.idx);
      if (wr_gnt.vld) wr_ptr <= next_ptr(wr_gnt.idx);
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [NUM_CH-1:0] s1_valid;
      logic [DW-1:0]     s1_data;

      // Two-stage read return. Stage 1 captures the handshake and stage 2
      // presents it. rdata holds its value between returns.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid <= '0;
          s1_data  <= '0;
          rvalid   <= '0;
          rdata    <= '0;
        end else begin
          s1_valid <= ch_rready;
          if (rd_gnt.vld) s1_data <= rd_word;
          rvalid <= s1_valid;
          if (|s1_valid) rdata <= s1_data;
        end
      end
    end else begin : g_lat1
      // Single-stage read return. The data is valid in the cycle after the
      // handshake, and rdata holds its value between returns.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rvalid <= '0;
          rdata  <= '0;
        end else begin
          rvalid <= ch_rready;
          if (rd_gnt.vld) rdata <= rd_word;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl. Three instances cover the configurations:
// a: 4 channels, round-robin, RD_LAT=1
// b: 2 channels, fixed priority, RD_LAT=1
// c: 2 channels, round-robin, RD_LAT=2
`timescale 1ns/1ps
module tb_mem_arb_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [3:0]      a_ren, a_rready, a_wen, a_wready, a_rvalid;
  logic [4*AW-1:0] a_raddr, a_waddr;
  logic [4*DW-1:0] a_wdata;
  logic [4*SW-1:0] a_wstrb;
  logic [DW-1:0]   a_rdata;

  logic [1:0]      b_ren, b_rready, b_wen, b_wready, b_rvalid;
  logic [2*AW-1:0] b_raddr, b_waddr;
  logic [2*DW-1:0] b_wdata;
  logic [2*SW-1:0] b_wstrb;
  logic [DW-1:0]   b_rdata;

  logic [1:0]      c_ren, c_rready, c_wen, c_wready, c_rvalid;
  logic [2*AW-1:0] c_raddr, c_waddr;
  logic [2*DW-1:0] c_wdata;
  logic [2*SW-1:0] c_wstrb;
  logic [DW-1:0]   c_rdata;

  mem_arb_ctrl #(.DEPTH(32), .DW(32), .NUM_CH(4), .ARB_RR(1'b1), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .ch_ren(a_ren), .ch_raddr(a_raddr), .ch_rready(a_rready),
    .ch_wen(a_wen), .ch_waddr(a_waddr), .ch_wdata(a_wdata), .ch_wstrb(a_wstrb),
    .ch_wready(a_wready), .rdata(a_rdata), .rvalid(a_rvalid)
  );

  mem_arb_ctrl #(.DEPTH(32), .DW(32), .NUM_CH(2), .ARB_RR(1'b0), .RD_LAT(1)) dut_b (
    .clk(clk), .rst(rst),
    .ch_ren(b_ren), .ch_raddr(b_raddr), .ch_rready(b_rready),
    .ch_wen(b_wen), .ch_waddr(b_waddr), .ch_wdata(b_wdata), .ch_wstrb(b_wstrb),
    .ch_wready(b_wready), .rdata(b_rdata), .rvalid(b_rvalid)
  );

  mem_arb_ctrl #(.DEPTH(32), .DW(32), .NUM_CH(2), .ARB_RR(1'b1), .RD_LAT(2)) dut_c (
    .clk(clk), .rst(rst),
    .ch_ren(c_ren), .ch_raddr(c_raddr), .ch_rready(c_rready),
    .ch_wen(c_wen), .ch_waddr(c_waddr), .ch_wdata(c_wdata), .ch_wstrb(c_wstrb),
    .ch_wready(c_wready), .rdata(c_rdata), .rvalid(c_rvalid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_ren = '0; a_raddr = '0; a_wen = '0; a_waddr = '0; a_wdata = '0; a_wstrb = '0;
    b_ren = '0; b_raddr = '0; b_wen = '0; b_waddr = '0; b_wdata = '0; b_wstrb = '0;
    c_ren = '0; c_raddr = '0; c_wen = '0; c_waddr = '0; c_wdata = '0; c_wstrb = '0;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    tick(); tick();
    tests++; if (a_rvalid !== 4'b0000) begin fails++; $display("FAIL reset_a_rvalid got=%b exp=0000", a_rvalid); end
    tests++; if (a_rdata !== 32'h0) begin fails++; $display("FAIL reset_a_rdata got=%h exp=0", a_rdata); end
    tests++; if (b_rvalid !== 2'b00) begin fails++; $display("FAIL reset_b_rvalid got=%b exp=00", b_rvalid); end
    tests++; if (c_rvalid !== 2'b00) begin fails++; $display("FAIL reset_c_rvalid got=%b exp=00", c_rvalid); end
    tests++; if (c_rdata !== 32'h0) begin fails++; $display("FAIL reset_c_rdata got=%h exp=0", c_rdata); end
    rst = 1'b0;
    tick();
    // a: ch2 reads, which moves rd_ptr to 3. c: ch0 reads and the read is
    // still in its pipeline when rst hits.
    a_ren = 4'b0100; a_raddr[2*AW +: AW] = 5'd7;
    c_ren = 2'b01;   c_raddr[0 +: AW] = 5'd0;
    #1;
    tests++; if (a_rready !== 4'b0100) begin fails++; $display("FAIL inflight_a_rready got=%b exp=0100", a_rready); end
    tick();
    a_ren = '0; c_ren = '0;
    tests++; if (a_rvalid !== 4'b0100) begin fails++; $display("FAIL inflight_a_rvalid got=%b exp=0100", a_rvalid); end
    tests++; if (c_rvalid !== 2'b00) begin fails++; $display("FAIL inflight_c_early got=%b exp=00", c_rvalid); end
    rst = 1'b1;
    #1;
    tests++; if (a_rvalid !== 4'b0000) begin fails++; $display("FAIL midrst_a_rvalid got=%b exp=0000", a_rvalid); end
    tests++; if (a_rdata !== 32'h0) begin fails++; $display("FAIL midrst_a_rdata got=%h exp=0", a_rdata); end
    tests++; if (c_rvalid !== 2'b00) begin fails++; $display("FAIL midrst_c_rvalid got=%b exp=00", c_rvalid); end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (c_rvalid !== 2'b00) begin fails++; $display("FAIL dropped_c_rvalid cyc=%0d got=%b exp=00", i, c_rvalid); end
      tests++; if (a_rvalid !== 4'b0000) begin fails++; $display("FAIL dropped_a_rvalid cyc=%0d got=%b exp=0000", i, a_rvalid); end
    end
    // rd_ptr must be back at 0, so channel 0 wins with all channels requesting.
    a_ren = 4'b1111;
    #1;
    tests++; if (a_rready !== 4'b0001) begin fails++; $display("FAIL ptr_after_reset got=%b exp=0001", a_rready); end
    tick();
    idle_all();
  endtask

  task automatic test_byte_strobe();
    idle_all();
    a_wen = 4'b0010; a_waddr[1*AW +: AW] = 5'd5;
    a_wdata[1*DW +: DW] = 32'hAABBCCDD; a_wstrb[1*SW +: SW] = 4'hF;
    #1;
    tests++; if (a_wready !== 4'b0010) begin fails++; $display("FAIL strb_wready got=%b exp=0010", a_wready); end
    tick();
    a_wdata[1*DW +: DW] = 32'h11223344; a_wstrb[1*SW +: SW] = 4'b0101;
    tick();
    idle_all();
    a_ren = 4'b1000; a_raddr[3*AW +: AW] = 5'd5;
    #1;
    tests++; if (a_rready !== 4'b1000) begin fails++; $display("FAIL strb_rready got=%b exp=1000", a_rready); end
    tick();
    idle_all();
    tests++; if (a_rvalid !== 4'b1000) begin fails++; $display("FAIL strb_rvalid got=%b exp=1000", a_rvalid); end
    tests++; if (a_rdata !== 32'hAA22CC44) begin fails++; $display("FAIL strb_rdata got=%h exp=aa22cc44", a_rdata); end
    tick();
    tests++; if (a_rvalid !== 4'b0000) begin fails++; $display("FAIL strb_pulse got=%b exp=0000", a_rvalid); end
    tests++; if (a_rdata !== 32'hAA22CC44) begin fails++; $display("FAIL strb_hold got=%h exp=aa22cc44", a_rdata); end
  endtask

  task automatic test_raw_bypass();
    // RD_LAT=1 instance: mem[3]=0, then a write and a read of word 3 in the
    // same cycle.
    idle_all();
    a_wen = 4'b0001; a_waddr[0 +: AW] = 5'd3; a_wdata[0 +: DW] = 32'h0; a_wstrb[0 +: SW] = 4'hF;
    tick();
    a_wdata[0 +: DW] = 32'hFFFF0000; a_wstrb[0 +: SW] = 4'b1100;
    a_ren = 4'b0010; a_raddr[1*AW +: AW] = 5'd3;
    #1;
    tests++; if (a_rready !== 4'b0010 || a_wready !== 4'b0001) begin
      fails++; $display("FAIL raw_grants got r=%b w=%b exp r=0010 w=0001", a_rready, a_wready); end
    tick();
    idle_all();
    tests++; if (a_rvalid !== 4'b0010) begin fails++; $display("FAIL raw_a_rvalid got=%b exp=0010", a_rvalid); end
    tests++; if (a_rdata !== 32'hFFFF0000) begin fails++; $display("FAIL raw_a_rdata got=%h exp=ffff0000", a_rdata); end
    // A zero strobe still takes the grant but must leave the word unchanged.
    a_wen = 4'b0001; a_waddr[0 +: AW] = 5'd3; a_wdata[0 +: DW] = 32'hFFFFFFFF; a_wstrb[0 +: SW] = 4'h0;
    #1;
    tests++; if (a_wready !== 4'b0001) begin fails++; $display("FAIL nostrb_wready got=%b exp=0001", a_wready); end
    tick();
    idle_all();
    a_ren = 4'b0001; a_raddr[0 +: AW] = 5'd3;
    tick();
    idle_all();
    tests++; if (a_rdata !== 32'hFFFF0000 || a_rvalid !== 4'b0001) begin
      fails++; $display("FAIL nostrb_rdata got=%h/%b exp=ffff0000/0001", a_rdata, a_rvalid); end
    // RD_LAT=2 instance: mem[3]=0x12345678, then a half-word bypass.
    c_wen = 2'b01; c_waddr[0 +: AW] = 5'd3; c_wdata[0 +: DW] = 32'h12345678; c_wstrb[0 +: SW] = 4'hF;
    tick();
    c_wdata[0 +: DW] = 32'hFFFF0000; c_wstrb[0 +: SW] = 4'b1100;
    c_ren = 2'b10; c_raddr[1*AW +: AW] = 5'd3;
    tick();
    idle_all();
    tests++; if (c_rvalid !== 2'b00) begin fails++; $display("FAIL raw_c_early got=%b exp=00", c_rvalid); end
    tick();
    tests++; if (c_rvalid !== 2'b10) begin fails++; $display("FAIL raw_c_rvalid got=%b exp=10", c_rvalid); end
    tests++; if (c_rdata !== 32'hFFFF5678) begin fails++; $display("FAIL raw_c_rdata got=%h exp=ffff5678", c_rdata); end
    tick();
    tests++; if (c_rvalid !== 2'b00) begin fails++; $display("FAIL raw_c_pulse got=%b exp=00", c_rvalid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_r;
    logic [3:0] exp_w;
    logic [3:0] prev_r;
    logic [3:0] seq [6];
    seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    idle_all();
    rst = 1'b1; #1; rst = 1'b0;
    // Reads: all four channels request. Writes: ch1 and ch2 request with zero
    // strobes, which exercises the write pointer on its own.
    a_ren = 4'b1111; a_wen = 4'b0110;
    prev_r = '0;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_r = 4'b0001 << (i % 4);
      exp_w = (i % 2 == 0) ? 4'b0010 : 4'b0100;
      tests++; if (a_rready !== exp_r) begin fails++; $display("FAIL rr_all cyc=%0d got=%b exp=%b", i, a_rready, exp_r); end
      tests++; if (a_wready !== exp_w) begin fails++; $display("FAIL rr_wr cyc=%0d got=%b exp=%b", i, a_wready, exp_w); end
      if (i > 0) begin
        tests++; if (a_rvalid !== prev_r) begin fails++; $display("FAIL rr_rvalid cyc=%0d got=%b exp=%b", i, a_rvalid, prev_r); end
      end
      prev_r = exp_r;
      tick();
    end
    a_ren = 4'b1011; a_wen = '0;
    for (int i = 0; i < 6; i++) begin
      #1;
      tests++; if (a_rready !== seq[i]) begin fails++; $display("FAIL rr_skip2 cyc=%0d got=%b exp=%b", i, a_rready, seq[i]); end
      tick();
    end
    idle_all();
  endtask

  task automatic test_fixed_priority();
    idle_all();
    b_ren = 2'b11; b_wen = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (b_rready !== 2'b01) begin fails++; $display("FAIL fp_rd cyc=%0d got=%b exp=01", i, b_rready); end
      tests++; if (b_wready !== 2'b01) begin fails++; $display("FAIL fp_wr cyc=%0d got=%b exp=01", i, b_wready); end
      tick();
    end
    b_ren = 2'b10;
    #1;
    tests++; if (b_rready !== 2'b10) begin fails++; $display("FAIL fp_rd_handover got=%b exp=10", b_rready); end
    b_wen = 2'b10;
    #1;
    tests++; if (b_wready !== 2'b10) begin fails++; $display("FAIL fp_wr_handover got=%b exp=10", b_wready); end
    tick();
    idle_all();
    tests++; if (b_rvalid !== 2'b10) begin fails++; $display("FAIL fp_rvalid got=%b exp=10", b_rvalid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_v;
    logic [31:0] exp_d;
    idle_all();
    c_wen = 2'b10; c_wstrb[1*SW +: SW] = 4'hF;
    for (int k = 0; k < 8; k++) begin
      c_waddr[1*AW +: AW] = AW'(k);
      c_wdata[1*DW +: DW] = 32'hC0DE0000 + 32'(k) * 32'h111;
      tick();
    end
    idle_all();
    // Read k is issued at iteration k and must return at iteration k+2.
    for (int j = 0; j <= 10; j++) begin
      exp_v = (j >= 2 && j <= 9) ? (2'b01 << ((j - 2) % 2)) : 2'b00;
      exp_d = 32'hC0DE0000 + 32'(j - 2) * 32'h111;
      tests++; if (c_rvalid !== exp_v) begin fails++; $display("FAIL b2b_rvalid it=%0d got=%b exp=%b", j, c_rvalid, exp_v); end
      if (j >= 2 && j <= 9) begin
        tests++; if (c_rdata !== exp_d) begin fails++; $display("FAIL b2b_rdata it=%0d got=%h exp=%h", j, c_rdata, exp_d); end
      end
      if (j < 8) begin
        c_ren = 2'b01 << (j % 2);
        c_raddr = '0;
        c_raddr[(j % 2)*AW +: AW] = AW'(j);
      end else begin
        c_ren = '0;
      end
      tick();
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_byte_strobe();
    test_raw_bypass();
    test_round_robin();
    test_fixed_priority();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
